flash_responder: RTL and testbench

FLASH_RESPONDER -- requirements
Module: flash_responder

---
 rtl/flash_responder.sv | 216 +++++++++++++++++++++
 tb/tb_flash_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_responder.sv
// flash_responder: chip-side model of a 16-bit word-mode NOR flash.
// Responds to the labkit flash interface with array reads, status reads,
// word program and block erase command sequences, plus flash_reset_b abort.
// Memory is held as the bitwise complement of the stored data, so flops and
// RAM that power up cleared present erased (16'hFFFF) content.
module flash_responder #(
  parameter int ADDR_BITS      = 8,
  parameter int BLOCK_BITS     = 4,
  parameter int PROGRAM_CYCLES = 16,
  parameter int ERASE_CYCLES   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] flash_address,
  inout  wire  [15:0] flash_data,
  input  logic        flash_ce_b,
  input  logic        flash_oe_b,
  input  logic        flash_we_b,
  input  logic        flash_reset_b,
  input  logic        flash_byte_b,
  output logic        flash_sts
);

  localparam int WORDS       = 2 ** ADDR_BITS;
  localparam int BLOCK_WORDS = 2 ** BLOCK_BITS;
  localparam int MAX_CYC     = (ERASE_CYCLES > PROGRAM_CYCLES) ? ERASE_CYCLES : PROGRAM_CYCLES;
  localparam int CNT_W       = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    ST_ARRAY       = 3'd0,
    ST_STATUS      = 3'd1,
    ST_PROG_SETUP  = 3'd2,
    ST_ERASE_SETUP = 3'd3,
    ST_PROGRAMMING = 3'd4,
    ST_ERASING     = 3'd5
  } state_t;

  // Status byte layout: ready, reserved, erase/sequence error, program/sequence error.
  function automatic logic [7:0] pack_sr(input logic sr7, input logic sr5, input logic sr4);
    pack_sr = {sr7, 1'b0, sr5, sr4, 4'b0000};
  endfunction

  // Complemented storage: 0 bits read back as 1 (erased).
  logic [15:0] mem_inv_q [0:WORDS-1];

  state_t                 state_q, state_d;
  logic                   sr7_q, sr7_d;
  logic                   sr5_q, sr5_d;
  logic                   sr4_q, sr4_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [15:0]            data_q, data_d;
  logic                   we_prev_q, we_prev_d;
  logic                   drive_q, drive_d;
  logic [15:0]            dout_q, dout_d;

  logic                   strobe_s;
  logic [ADDR_BITS-1:0]   rd_idx_s;
  logic                   mem_we_s;
  logic [ADDR_BITS-1:0]   mem_waddr_s;
  logic [15:0]            mem_wdata_s;
  logic                   unused_ok_s;

  assign rd_idx_s    = flash_address[ADDR_BITS:1];
  assign strobe_s    = (~we_prev_q) & flash_we_b & (~flash_ce_b);
  assign unused_ok_s = ^{flash_address[23:ADDR_BITS+1], flash_address[0], flash_byte_b};

  assign flash_sts  = sr7_q;
  assign flash_data = drive_q ? dout_q : 16'hzzzz;

  // Next-state, status, counter and memory-write decode for the command protocol.
  always_comb begin
    state_d     = state_q;
    sr7_d       = sr7_q;
    sr5_d       = sr5_q;
    sr4_d       = sr4_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_prev_d   = flash_we_b;
    drive_d     = (~flash_ce_b) & (~flash_oe_b) & flash_we_b;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_q;
    mem_wdata_s = 16'h0000;

    if (state_q == ST_ARRAY) begin
      dout_d = ~mem_inv_q[rd_idx_s];
    end else begin
      dout_d = {8'h00, pack_sr(sr7_q, sr5_q, sr4_q)};
    end

    if (reset || !flash_reset_b) begin
      // Abort: nothing in flight may resume, memory stays as it was left.
      state_d = ST_ARRAY;
      sr7_d   = 1'b1;
      sr5_d   = 1'b0;
      sr4_d   = 1'b0;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_ARRAY, ST_STATUS: begin
          if (strobe_s) begin
            case (flash_data)
              16'h00FF: state_d = ST_ARRAY;
              16'h0070: state_d = ST_STATUS;
              16'h0050: begin
                sr5_d = 1'b0;
                sr4_d = 1'b0;
              end
              16'h0040, 16'h0010: state_d = ST_PROG_SETUP;
              16'h0020: state_d = ST_ERASE_SETUP;
              default: state_d = ST_ARRAY;
            endcase
          end else begin
            state_d = state_q;
          end
        end
        ST_PROG_SETUP: begin
          if (strobe_s) begin
            addr_d  = rd_idx_s;
            data_d  = flash_data;
            cnt_d   = {CNT_W{1'b0}};
            sr7_d   = 1'b0;
            state_d = ST_PROGRAMMING;
          end else begin
            state_d = state_q;
          end
        end
        ST_ERASE_SETUP: begin
          if (strobe_s) begin
            if (flash_data == 16'h00D0) begin
              addr_d  = rd_idx_s;
              cnt_d   = {CNT_W{1'b0}};
              sr7_d   = 1'b0;
              state_d = ST_ERASING;
            end else begin
              sr5_d   = 1'b1;
              sr4_d   = 1'b1;
              state_d = ST_STATUS;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_PROGRAMMING: begin
          if (cnt_q == CNT_W'(PROGRAM_CYCLES - 1)) begin
            // Programming can only clear bits: set bits in the complement.
            mem_we_s    = 1'b1;
            mem_waddr_s = addr_q;
            mem_wdata_s = mem_inv_q[addr_q] | ~data_q;
            sr7_d       = 1'b1;
            cnt_d       = {CNT_W{1'b0}};
            state_d     = ST_STATUS;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ERASING: begin
          if (cnt_q < CNT_W'(BLOCK_WORDS)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = {addr_q[ADDR_BITS-1:BLOCK_BITS], cnt_q[BLOCK_BITS-1:0]};
            mem_wdata_s = 16'h0000;
          end else begin
            mem_we_s = 1'b0;
          end
          if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
            sr7_d   = 1'b1;
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_STATUS;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_ARRAY;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Control, status and read-path registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ARRAY;
      sr7_q     <= 1'b1;
      sr5_q     <= 1'b0;
      sr4_q     <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      addr_q    <= {ADDR_BITS{1'b0}};
      data_q    <= 16'h0000;
      we_prev_q <= 1'b1;
      drive_q   <= 1'b0;
      dout_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      sr7_q     <= sr7_d;
      sr5_q     <= sr5_d;
      sr4_q     <= sr4_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_prev_q <= we_prev_d;
      drive_q   <= drive_d;
      dout_q    <= dout_d;
    end
  end

  // Memory array write port; contents deliberately survive every reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_inv_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: power-on read, program, reprogram,
// block erase, sequence error, flash_reset_b abort and reset mid-program.
module tb_flash_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] flash_address;
  logic        flash_ce_b, flash_oe_b, flash_we_b, flash_reset_b, flash_byte_b;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  tri0  [15:0] flash_data;
  wire         flash_sts;

  int total = 0;
  int bad   = 0;
  int n;
  int errs;
  logic [15:0] v;

  assign flash_data = tb_drv ? tb_wdata : 16'hzzzz;

  flash_responder dut (
    .clk           (clk),
    .reset         (reset),
    .flash_address (flash_address),
    .flash_data    (flash_data),
    .flash_ce_b    (flash_ce_b),
    .flash_oe_b    (flash_oe_b),
    .flash_we_b    (flash_we_b),
    .flash_reset_b (flash_reset_b),
    .flash_byte_b  (flash_byte_b),
    .flash_sts     (flash_sts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus write: we_b low for one edge, then high with ce_b low (the strobe edge).
  task automatic wr(input logic [23:0] a, input logic [15:0] d);
    flash_address = a;
    tb_wdata = d;
    tb_drv = 1'b1;
    flash_ce_b = 1'b0;
    flash_we_b = 1'b0;
    tick();
    flash_we_b = 1'b1;
    tick();
    tb_drv = 1'b0;
    flash_ce_b = 1'b1;
  endtask

  // Bus read: data is valid one clock after the address is sampled.
  task automatic rd(input logic [23:0] a, output logic [15:0] d);
    flash_address = a;
    flash_ce_b = 1'b0;
    flash_oe_b = 1'b0;
    tick();
    @(negedge clk);
    d = flash_data;
    flash_oe_b = 1'b1;
    flash_ce_b = 1'b1;
    tick();
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (flash_sts === 1'b0 && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  task automatic prog(input logic [23:0] a, input logic [15:0] d);
    int c;
    wr(24'h0, 16'h0040);
    wr(a, d);
    wait_ready(c);
    wr(24'h0, 16'h00FF);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    flash_address = 24'h0;
    flash_ce_b = 1'b1;
    flash_oe_b = 1'b1;
    flash_we_b = 1'b1;
    flash_reset_b = 1'b1;
    flash_byte_b = 1'b1;
    tb_drv = 1'b0;
    tb_wdata = 16'h0000;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state and power-on read.
    chk("rst_sts", {15'd0, flash_sts}, 16'h0001);
    chk("rst_hiz", flash_data, 16'h0000);
    rd(24'h000010, v);
    chk("por_read", v, 16'hFFFF);
    chk("oe_off_hiz", flash_data, 16'h0000);

    // Program 16'h1234 at byte address 6.
    wr(24'h0, 16'h0040);
    wr(24'h000006, 16'h1234);
    chk("prog_busy", {15'd0, flash_sts}, 16'h0000);
    wait_ready(n);
    chk("prog_cycles", 16'(n), 16'd16);
    rd(24'h0, v);
    chk("prog_status", v, 16'h0080);
    wr(24'h0, 16'h00FF);
    rd(24'h000006, v);
    chk("prog_read", v, 16'h1234);

    // Reprogram ANDs into the existing word.
    wr(24'h0, 16'h0040);
    wr(24'h000006, 16'h00FF);
    wait_ready(n);
    rd(24'h0, v);
    chk("reprog_status", v, 16'h0080);
    wr(24'h0, 16'h00FF);
    rd(24'h000006, v);
    chk("reprog_read", v, 16'h0034);

    // Block erase of block 0; word 16 lives in block 1.
    prog(24'h000020, 16'hA5A5);
    wr(24'h0, 16'h0020);
    wr(24'h000004, 16'h00D0);
    wait_ready(n);
    chk("erase_cycles", 16'(n), 16'd64);
    wr(24'h0, 16'h00FF);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      rd(24'(2 * i), v);
      if (v !== 16'hFFFF) errs++;
    end
    chk("erase_block", 16'(errs), 16'd0);
    rd(24'h000020, v);
    chk("erase_neighbour", v, 16'hA5A5);

    // Erase sequence error and clear-status.
    wr(24'h0, 16'h0020);
    wr(24'h0, 16'h00AB);
    rd(24'h0, v);
    chk("seq_err_status", v, 16'h00B0);
    wr(24'h0, 16'h0050);
    rd(24'h0, v);
    chk("clear_status", v, 16'h0080);
    wr(24'h0, 16'h00FF);

    // Abort an erase after five erase cycles with flash_reset_b.
    prog(24'h000008, 16'h4444);
    prog(24'h00000A, 16'h5555);
    prog(24'h00001E, 16'hF0F0);
    wr(24'h0, 16'h0020);
    wr(24'h0, 16'h00D0);
    repeat (5) tick();
    flash_reset_b = 1'b0;
    tick();
    chk("abort_sts", {15'd0, flash_sts}, 16'h0001);
    wr(24'h0, 16'h0070);
    flash_reset_b = 1'b1;
    tick();
    rd(24'h000000, v);
    chk("abort_w0", v, 16'hFFFF);
    rd(24'h000008, v);
    chk("abort_w4", v, 16'hFFFF);
    rd(24'h00000A, v);
    chk("abort_w5", v, 16'h5555);
    rd(24'h00001E, v);
    chk("abort_w15", v, 16'hF0F0);
    repeat (80) tick();
    chk("abort_no_resume_sts", {15'd0, flash_sts}, 16'h0001);
    rd(24'h00000A, v);
    chk("abort_no_resume_w5", v, 16'h5555);

    // Reset in the middle of a program leaves the word untouched.
    wr(24'h0, 16'h0040);
    wr(24'h000030, 16'h0000);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_prog_sts", {15'd0, flash_sts}, 16'h0001);
    repeat (20) tick();
    rd(24'h000030, v);
    chk("rst_mid_prog_word", v, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
